// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} hstate_t;
  localparam int REG_W     = 5;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/hazard_unit_if.sv
// Control bundle between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_unit_if import hazard_pkg::*; #(parameter int CNT_W = DEF_CNT_W);
  logic             ihit;
  logic             dhit;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_dren;
  logic [REG_W-1:0] ex_rd;
  logic             mem_dren;
  logic             mem_dwen;
  logic             branch_taken;
  logic             wb_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [CNT_W-1:0] lu_events;

  modport master (
    output ihit, dhit, id_rs, id_rt, ex_dren, ex_rd, mem_dren, mem_dwen,
           branch_taken, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, stall_cycles, flush_events, lu_events
  );

  modport slave (
    input  ihit, dhit, id_rs, id_rt, ex_dren, ex_rd, mem_dren, mem_dwen,
           branch_taken, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           halted, stall_cycles, flush_events, lu_events
  );
endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (en && inc && !(&r_count)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stalls, bubbles and flushes for load-use, redirects,
// memory waits and halt; outputs are combinational from state and inputs.
module hazard_unit import hazard_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          CLK,
  input  logic          nRST,
  hazard_unit_if.slave  bus
);
  hstate_t r_state;
  hstate_t w_next_state;
  logic    w_dwait;
  logic    w_lu;
  logic    w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic    w_ifid_flush, w_idex_flush;
  logic    w_stall_inc, w_flush_inc, w_lu_inc;
  logic    w_cnt_en;

  assign w_dwait = (bus.mem_dren | bus.mem_dwen) & ~bus.dhit;
  assign w_lu    = bus.ex_dren & (bus.ex_rd != '0) &
                   ((bus.ex_rd == bus.id_rs) | (bus.ex_rd == bus.id_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_en      = 1'b0;
    w_ifid_en    = 1'b0;
    w_idex_en    = 1'b0;
    w_exmem_en   = 1'b0;
    w_memwb_en   = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_lu_inc     = 1'b0;
    case (r_state)
      RUN, DWAIT: begin
        if (bus.wb_halt) begin
          w_next_state = HALT;
        end else if (r_state == RUN && w_dwait) begin
          w_next_state = DWAIT;
        end else if (r_state == DWAIT && bus.dhit) begin
          w_next_state = RUN;
        end

        if (bus.wb_halt || w_dwait || (bus.branch_taken && !bus.ihit)) begin
          // full freeze: everything already defaulted to 0
        end else if (bus.branch_taken) begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '1;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (w_lu) begin
          {w_idex_en, w_exmem_en, w_memwb_en} = '1;
          w_idex_flush = 1'b1;
          w_lu_inc     = 1'b1;
        end else if (!bus.ihit) begin
          {w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '1;
          w_ifid_flush = 1'b1;
        end else begin
          {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = '1;
        end
        w_stall_inc = ~w_pc_en;
      end
      default: begin
        w_next_state = HALT;
      end
    endcase
  end

  // Reset holds every latch closed regardless of the inputs.
  assign bus.pc_en      = w_pc_en      & nRST;
  assign bus.ifid_en    = w_ifid_en    & nRST;
  assign bus.idex_en    = w_idex_en    & nRST;
  assign bus.exmem_en   = w_exmem_en   & nRST;
  assign bus.memwb_en   = w_memwb_en   & nRST;
  assign bus.ifid_flush = w_ifid_flush & nRST;
  assign bus.idex_flush = w_idex_flush & nRST;
  assign bus.halted     = (r_state == HALT);

  assign w_cnt_en = (r_state != HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .nRST(nRST), .inc(w_stall_inc), .en(w_cnt_en), .count(bus.stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .nRST(nRST), .inc(w_flush_inc), .en(w_cnt_en), .count(bus.flush_events)
  );
  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .CLK(CLK), .nRST(nRST), .inc(w_lu_inc), .en(w_cnt_en), .count(bus.lu_events)
  );
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: single-cycle decision table plus multi-cycle sequences.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int CW = 4;
  // Output pattern order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] P_RUN    = 7'b11111_00;
  localparam logic [6:0] P_FREEZE = 7'b00000_00;
  localparam logic [6:0] P_REDIR  = 7'b11111_11;
  localparam logic [6:0] P_LU     = 7'b00111_01;
  localparam logic [6:0] P_NOFET  = 7'b01111_10;

  logic CLK;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  hazard_unit_if #(.CNT_W(CW)) bus ();
  hazard_unit #(.CNT_W(CW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       ihit, dhit, ex_dren, mem_dren, mem_dwen, br, halt;
    logic [4:0] rs, rt, rd;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush};
  endfunction

  task automatic apply(input vec_t v);
    bus.ihit = v.ihit; bus.dhit = v.dhit; bus.ex_dren = v.ex_dren;
    bus.mem_dren = v.mem_dren; bus.mem_dwen = v.mem_dwen;
    bus.branch_taken = v.br; bus.wb_halt = v.halt;
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.ex_rd = v.rd;
  endtask

  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.ex_dren = 1'b0; bus.mem_dren = 1'b0;
    bus.mem_dwen = 1'b0; bus.branch_taken = 1'b0; bus.wb_halt = 1'b0;
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.ex_rd = 5'd3;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    //          name        ihit dhit ldr  mrd  mwr  br   hlt  rs     rt     rd     exp
    vecs[0]  = '{"normal",   1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3, P_RUN};
    vecs[1]  = '{"lu_rs",    1, 0, 1, 0, 0, 0, 0, 5'd5, 5'd2, 5'd5, P_LU};
    vecs[2]  = '{"lu_rt",    1, 0, 1, 0, 0, 0, 0, 5'd3, 5'd5, 5'd5, P_LU};
    vecs[3]  = '{"lu_r0",    1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, P_RUN};
    vecs[4]  = '{"noload",   1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, P_RUN};
    vecs[5]  = '{"nofetch",  0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd3, P_NOFET};
    vecs[6]  = '{"lu_nofet", 0, 0, 1, 0, 0, 0, 0, 5'd7, 5'd2, 5'd7, P_LU};
    vecs[7]  = '{"redirect", 1, 0, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3, P_REDIR};
    vecs[8]  = '{"br_wait",  0, 0, 0, 0, 0, 1, 0, 5'd1, 5'd2, 5'd3, P_FREEZE};
    vecs[9]  = '{"br_lu",    1, 0, 1, 0, 0, 1, 0, 5'd4, 5'd2, 5'd4, P_REDIR};
    vecs[10] = '{"ld_hit",   1, 1, 0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd3, P_RUN};
    vecs[11] = '{"st_hit",   0, 1, 0, 0, 1, 0, 0, 5'd1, 5'd2, 5'd3, P_NOFET};

    idle();
    nRST = 1'b0;
    #1;
    chk("rst_outs",   32'(outs()), 32'(P_FREEZE));
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_stall",  32'(bus.stall_cycles), 32'd0);
    chk("rst_state",  32'(dut.r_state), 32'(RUN));
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      apply(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end

    // Load-use: one bubble counted, then r0 never stalls.
    do_reset();
    bus.ex_dren = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
    #1 chk("lu_outs", 32'(outs()), 32'(P_LU));
    @(negedge CLK);
    chk("lu_events", 32'(bus.lu_events), 32'd1);
    chk("lu_stall",  32'(bus.stall_cycles), 32'd1);
    bus.ex_rd = 5'd0; bus.id_rs = 5'd0;
    #1 chk("lu_r0_outs", 32'(outs()), 32'(P_RUN));
    @(negedge CLK);
    chk("lu_r0_events", 32'(bus.lu_events), 32'd1);

    // Redirect waits for the fetch, then flushes both front latches.
    do_reset();
    bus.branch_taken = 1'b1; bus.ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("br_hold", 32'(outs()), 32'(P_FREEZE));
      @(negedge CLK);
    end
    bus.ihit = 1'b1;
    #1 chk("br_go", 32'(outs()), 32'(P_REDIR));
    @(negedge CLK);
    bus.branch_taken = 1'b0;
    chk("br_flush_ev", 32'(bus.flush_events), 32'd1);
    chk("br_stall",    32'(bus.stall_cycles), 32'd2);

    // Data wait: three frozen cycles in DWAIT, released on dhit.
    do_reset();
    bus.mem_dren = 1'b1; bus.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("dw_freeze", 32'(outs()), 32'(P_FREEZE));
      @(negedge CLK);
      chk("dw_state", 32'(dut.r_state), 32'(DWAIT));
    end
    bus.dhit = 1'b1;
    #1 chk("dw_release", 32'(outs()), 32'(P_RUN));
    @(negedge CLK);
    chk("dw_back_run", 32'(dut.r_state), 32'(RUN));
    chk("dw_stall",    32'(bus.stall_cycles), 32'd3);

    // dwait + redirect + load-use together: freeze, only the stall counter moves.
    do_reset();
    bus.mem_dren = 1'b1; bus.dhit = 1'b0; bus.branch_taken = 1'b1;
    bus.ex_dren = 1'b1; bus.ex_rd = 5'd9; bus.id_rt = 5'd9;
    #1 chk("pri_outs", 32'(outs()), 32'(P_FREEZE));
    @(negedge CLK);
    chk("pri_stall", 32'(bus.stall_cycles), 32'd1);
    chk("pri_flush", 32'(bus.flush_events), 32'd0);
    chk("pri_lu",    32'(bus.lu_events), 32'd0);

    // Halt during a data wait is sticky until reset.
    do_reset();
    bus.mem_dren = 1'b1; bus.dhit = 1'b0;
    @(negedge CLK);
    chk("hlt_dwait", 32'(dut.r_state), 32'(DWAIT));
    bus.wb_halt = 1'b1;
    #1 chk("hlt_outs",  32'(outs()), 32'(P_FREEZE));
    chk("hlt_not_yet",  32'(bus.halted), 32'd0);
    @(negedge CLK);
    bus.wb_halt = 1'b0;
    chk("hlt_set",   32'(bus.halted), 32'd1);
    chk("hlt_stall", 32'(bus.stall_cycles), 32'd2);
    for (int i = 0; i < 4; i++) begin
      bus.ihit = i[0]; bus.dhit = ~i[0];
      #1 chk("hlt_hold", 32'(bus.halted), 32'd1);
      chk("hlt_frozen", 32'(outs()), 32'(P_FREEZE));
      @(negedge CLK);
    end
    chk("hlt_cnt_frozen", 32'(bus.stall_cycles), 32'd2);
    nRST = 1'b0;
    #1 chk("hlt_cleared", 32'(bus.halted), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Saturation of the 4-bit stall counter.
    do_reset();
    bus.ihit = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge CLK);
    chk("sat_15", 32'(bus.stall_cycles), 32'd15);
    @(negedge CLK);
    chk("sat_hold", 32'(bus.stall_cycles), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard control for the five-stage core. It sits alongside `forward_unit` and decides when each pipeline latch advances, holds, or is cleared. Forwarding covers ALU-to-ALU dependencies; this block covers the cases forwarding cannot:
- load-use dependencies,
- taken-branch/jump redirects,
- instruction- and data-memory wait cycles,
- halt.

It is a Mealy controller: a small state machine plus saturating event counters, with outputs that drive the latch enables and flushes and the PC enable.

## Interface
Parameters:
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `CLK` in 1: core clock. All state changes on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction memory returned the fetch this cycle.
- `dhit` in 1: data memory completed the MEM-stage access this cycle.
- `id_rs`, `id_rt` in 5 each: source registers of the instruction in ID.
- `ex_dren` in 1: instruction in EX is a load.
- `ex_rd` in 5: destination register of the instruction in EX.
- `mem_dren`, `mem_dwen` in 1 each: MEM-stage load / store request.
- `branch_taken` in 1: EX resolved a taken branch or jump; the PC mux already selects the target.
- `wb_halt` in 1: a halt instruction is in WB.
- `pc_en` out 1: PC enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: latch enables.
- `ifid_flush`, `idex_flush` out 1 each: synchronous clear of the latch to a bubble. A flush takes effect only when the same latch's enable is 1.
- `halted` out 1: sticky halt indication.
- `stall_cycles` out `CNT_W`: cycles with `pc_en` = 0 while in RUN or DWAIT.
- `flush_events` out `CNT_W`: count of redirects.
- `lu_events` out `CNT_W`: count of load-use bubbles.

## Operation
Definitions:
- `dwait = (mem_dren | mem_dwen) & ~dhit`
- `lu = ex_dren & (ex_rd != 0) & ((ex_rd == id_rs) | (ex_rd == id_rt))`

State machine:
- States: RUN, DWAIT, HALT.
- RUN → HALT on `wb_halt`. This has the highest priority and overrides every other input.
- RUN → DWAIT on `dwait`.
- DWAIT → RUN on `dhit`.
- DWAIT → HALT on `wb_halt`.
- HALT is absorbing until reset.

Outputs in RUN and DWAIT, first matching rule wins:
1. `wb_halt`: all enables 0, all flushes 0.
2. `dwait`: all enables 0. The whole pipeline freezes.
3. `branch_taken` and `~ihit`: all enables 0. The branch is held in EX until the fetch settles.
4. `branch_taken` and `ihit`:
   - all enables 1;
   - `ifid_flush` = 1 and `idex_flush` = 1;
   - `flush_events` increments.
5. `lu`:
   - `pc_en` = 0, `ifid_en` = 0;
   - `idex_en` = 1 with `idex_flush` = 1 (bubble), `exmem_en` = 1, `memwb_en` = 1;
   - `lu_events` increments.
6. `~ihit`:
   - `pc_en` = 0, `ifid_en` = 1 with `ifid_flush` = 1 (bubble into ID);
   - the remaining enables are 1.
7. Otherwise: all enables 1, no flush.

HALT state:
- All enables 0, all flushes 0.
- `halted` = 1.
- Counters frozen.

Counters:
- All three counters saturate at all-ones and never wrap.
- `stall_cycles` increments in every RUN/DWAIT cycle where `pc_en` = 0. This includes the `wb_halt` cycle.
- Counters reset to 0.

## Timing
- Outputs are combinational from the current state and inputs, valid in the same cycle. State and counters update on the rising edge of `CLK`.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM, `lu` deasserts, and `forward_unit` supplies the value.
- A redirect costs two bubbles, IF/ID and ID/EX, applied on the cycle `branch_taken` and `ihit` are both high.
- `halted` goes high the cycle after `wb_halt` is sampled high.
- During reset (`nRST` low):
  - state is RUN;
  - all enables and flushes are forced to 0;
  - `halted` is 0;
  - counters are 0.
- Reset deassertion mid-stall resumes in RUN with no memory of the prior stall.
- Simultaneous `dwait` and `branch_taken`: `dwait` wins. The redirect is re-evaluated once `dhit` arrives; `branch_taken` stays high because EX was frozen.
- Simultaneous `lu` and `branch_taken`: redirect wins. The ID instruction is flushed, so no bubble is counted.

## Structure
- `hazard_pkg` holds:
  - the `hstate_t` enum {RUN, DWAIT, HALT};
  - `REG_W` = 5;
  - the default `CNT_W` = 16.
- One sub-module, `sat_counter` (parameter `W`; ports `CLK`, `nRST`, `inc`, `en`, `count`), instantiated three times.

## Test plan
- Load-use: `ex_dren`=1, `ex_rd`=5, `id_rs`=5, `ihit`=1.
  - Expect `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - Expect `lu_events` = 1 the next cycle.
  - Repeat with `ex_rd`=0: no stall.
- Redirect: `branch_taken`=1 with `ihit`=0 for 2 cycles, then `ihit`=1.
  - Expect all enables 0 for 2 cycles, then `ifid_flush`=1, `idex_flush`=1, and all enables 1.
  - Expect `flush_events`=1 and `stall_cycles`=2.
- Data wait: `mem_dren`=1, `dhit`=0 for 3 cycles, then `dhit`=1.
  - State goes RUN→DWAIT→…→RUN.
  - All enables 0 for 3 cycles, enables 1 on the `dhit` cycle.
- Priority: `dwait`, `branch_taken`, and `lu` all high at once.
  - Expect a full freeze and no counter increment except `stall_cycles`.
- Halt: `wb_halt`=1 mid-`dwait`.
  - `halted`=1 next cycle and stays 1 with `dhit`/`ihit` toggling.
  - Asserting `nRST` low clears `halted`.
- Saturation: with `CNT_W`=4, drive 20 `~ihit` cycles. Expect `stall_cycles` = 15 and holding.
